// File: rtl/alu_op_sequencer.sv
// ---------------------------------------------------------------------------
// alu_op_sequencer
//
// Sequences an external combinational 8-bit ALU. Op commands (op, ra, rb, rd)
// are buffered in a DEPTH-entry FIFO. For each command the block latches the
// operands from its NREGS x 8 register file into alu_a/alu_b/alu_n, captures
// the ALU result, condition codes and write enable one cycle later, and then
// writes the result back to rd.
//
// Optional feature macro: ALU_SEQ_FWD_EN
//   defined   : WB chains straight into EXEC when the FIFO holds a command
//               (2 cycles/op). The result still in the capture registers is
//               forwarded to the operands.
//   undefined : WB always returns to IDLE (3 cycles/op). There is no
//               forwarding logic.
//
// Ports
//   clk, reset             rising-edge clock; asynchronous active-high reset
//   cmd_valid/cmd_ready    command handshake (ready iff FIFO count < DEPTH)
//   cmd_op/ra/rb/rd        command fields
//   ld_en/ld_addr/ld_data  host preload of one register-file entry
//   alu_a/alu_b/alu_n      registered ALU operands and opcode
//   alu_r/alu_cc/alu_we    ALU result, condition codes and write enable
//   busy                   FSM not idle, or FIFO not empty
//   done/done_err/done_rd  one-cycle completion pulse, no-writeback flag,
//                          destination register
//   status_cc              cc of the last command that wrote back
//   dbg_addr/dbg_data      combinational register-file read port
// ---------------------------------------------------------------------------
module alu_op_sequencer #(
    parameter int  DEPTH = 4,
    parameter int  NREGS = 8,
    localparam int RA    = $clog2(NREGS)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic [3:0]    cmd_op,
    input  logic [RA-1:0] cmd_ra,
    input  logic [RA-1:0] cmd_rb,
    input  logic [RA-1:0] cmd_rd,
    input  logic          ld_en,
    input  logic [RA-1:0] ld_addr,
    input  logic [7:0]    ld_data,
    output logic [7:0]    alu_a,
    output logic [7:0]    alu_b,
    output logic [3:0]    alu_n,
    input  logic [7:0]    alu_r,
    input  logic [3:0]    alu_cc,
    input  logic          alu_we,
    output logic          busy,
    output logic          done,
    output logic          done_err,
    output logic [RA-1:0] done_rd,
    output logic [3:0]    status_cc,
    input  logic [RA-1:0] dbg_addr,
    output logic [7:0]    dbg_data
);

    localparam int PW = $clog2(DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_EXEC,
        ST_WB
    } state_t;

    typedef struct packed {
        logic [3:0]    op;
        logic [RA-1:0] ra;
        logic [RA-1:0] rb;
        logic [RA-1:0] rd;
    } cmd_t;

    // Command FIFO
    cmd_t          r_fifo [DEPTH];
    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_rd_ptr;
    logic [PW:0]   r_count;
    cmd_t          w_cmd_in;
    cmd_t          w_head;
    logic          w_push;
    logic          w_pop;
    logic          w_empty;

    // FSM and datapath
    state_t        r_state;
    state_t        w_state_nxt;
    logic [7:0]    r_rf [NREGS];
    logic [7:0]    r_alu_a;
    logic [7:0]    r_alu_b;
    logic [3:0]    r_alu_n;
    logic [RA-1:0] r_rd_q;
    logic [7:0]    r_r_q;
    logic [3:0]    r_cc_q;
    logic          r_we_q;
    logic [3:0]    r_status_cc;
    logic [7:0]    w_opa;
    logic [7:0]    w_opb;
    logic          w_wb_write;

    // -----------------------------------------------------------------------
    // FIFO
    // -----------------------------------------------------------------------
    assign w_cmd_in  = '{op: cmd_op, ra: cmd_ra, rb: cmd_rb, rd: cmd_rd};
    assign w_head    = r_fifo[r_rd_ptr];
    assign w_empty   = (r_count == '0);
    // Readiness depends only on the stored count: a pop in a full cycle does
    // not open a slot until the next cycle.
    assign cmd_ready = (r_count < (PW+1)'(DEPTH));
    assign w_push    = cmd_valid & cmd_ready;

    // NOTE: FIFO storage has no reset; r_count alone decides which entries
    // are meaningful, so clearing the array would only add reset fan-out.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fifo[r_wr_ptr] <= w_cmd_in;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // -----------------------------------------------------------------------
    // FSM
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // NOTE: every output of this block gets a default before the case, so
    // no path leaves a signal unassigned and no latch is inferred. Blocking
    // assignments are correct here because this is combinational logic.
    always_comb begin
        w_state_nxt = r_state;
        w_pop       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (!w_empty) begin
                    w_pop       = 1'b1;
                    w_state_nxt = ST_EXEC;
                end
            end
            ST_EXEC: begin
                w_state_nxt = ST_WB;
            end
            ST_WB: begin
`ifdef ALU_SEQ_FWD_EN
                if (!w_empty) begin
                    w_pop       = 1'b1;
                    w_state_nxt = ST_EXEC;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
`else
                w_state_nxt = ST_IDLE;
`endif
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // Operand selection. A same-cycle ld_en is deliberately not forwarded;
    // the latch sees the register's current contents.
    // -----------------------------------------------------------------------
    always_comb begin
        w_opa = r_rf[w_head.ra];
        w_opb = r_rf[w_head.rb];
`ifdef ALU_SEQ_FWD_EN
        // A pop in WB happens on the same edge as the writeback, so the
        // register file still holds the old value of rd_q.
        if (r_state == ST_WB && r_we_q && w_head.ra == r_rd_q) begin
            w_opa = r_r_q;
        end
        if (r_state == ST_WB && r_we_q && w_head.rb == r_rd_q) begin
            w_opb = r_r_q;
        end
`endif
    end

    assign w_wb_write = (r_state == ST_WB) && r_we_q;

    // -----------------------------------------------------------------------
    // ALU operand, capture and status registers
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_alu_a     <= '0;
            r_alu_b     <= '0;
            r_alu_n     <= '0;
            r_rd_q      <= '0;
            r_r_q       <= '0;
            r_cc_q      <= '0;
            r_we_q      <= 1'b0;
            r_status_cc <= '0;
        end else begin
            if (w_pop) begin
                r_alu_a <= w_opa;
                r_alu_b <= w_opb;
                r_alu_n <= w_head.op;
                r_rd_q  <= w_head.rd;
            end
            if (r_state == ST_EXEC) begin
                r_r_q  <= alu_r;
                r_cc_q <= alu_cc;
                r_we_q <= alu_we;
            end
            if (w_wb_write) begin
                r_status_cc <= r_cc_q;
            end
        end
    end

    // -----------------------------------------------------------------------
    // Register file. The host preload yields to a writeback to the same
    // address on the same edge.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NREGS; i++) begin
                r_rf[i] <= '0;
            end
        end else begin
            if (ld_en && !(w_wb_write && ld_addr == r_rd_q)) begin
                r_rf[ld_addr] <= ld_data;
            end
            if (w_wb_write) begin
                r_rf[r_rd_q] <= r_r_q;
            end
        end
    end

    // -----------------------------------------------------------------------
    // Outputs
    // -----------------------------------------------------------------------
    assign alu_a     = r_alu_a;
    assign alu_b     = r_alu_b;
    assign alu_n     = r_alu_n;
    assign status_cc = r_status_cc;
    assign done      = (r_state == ST_WB);
    assign done_err  = done && !r_we_q;
    assign done_rd   = done ? r_rd_q : '0;
    assign busy      = (r_state != ST_IDLE) || !w_empty;
    assign dbg_data  = r_rf[dbg_addr];

endmodule

// File: tb/tb_alu_op_sequencer.sv
// ---------------------------------------------------------------------------
// tb_alu_op_sequencer
//
// Bench for alu_op_sequencer with a stand-in combinational ALU. Stimulus
// pushes hand-computed expectations into a queue; an independent monitor pops
// one entry per done pulse and checks done_rd/done_err, and on the following
// cycle the written-back register and status_cc. Building with
// ALU_SEQ_FWD_EN defined selects the 2-cycle spacing between chained ops.
//
// Stand-in ALU: 0 add, 1 sub, 2 add, 3 and, 4 or, 5 xor, 6 max, 7 min,
// 8..15 we=0. cc = {op>=6, 0, r==0, op<=2} for defined ops.
// ---------------------------------------------------------------------------
module tb_alu_op_sequencer;

    localparam int DEPTH = 4;
    localparam int NREGS = 8;
    localparam int RA    = 3;

    logic          clk = 1'b0;
    logic          reset;
    logic          cmd_valid;
    logic          cmd_ready;
    logic [3:0]    cmd_op;
    logic [RA-1:0] cmd_ra;
    logic [RA-1:0] cmd_rb;
    logic [RA-1:0] cmd_rd;
    logic          ld_en;
    logic [RA-1:0] ld_addr;
    logic [7:0]    ld_data;
    logic [7:0]    alu_a;
    logic [7:0]    alu_b;
    logic [3:0]    alu_n;
    logic [7:0]    alu_r;
    logic [3:0]    alu_cc;
    logic          alu_we;
    logic          busy;
    logic          done;
    logic          done_err;
    logic [RA-1:0] done_rd;
    logic [3:0]    status_cc;
    logic [RA-1:0] dbg_addr;
    logic [7:0]    dbg_data;

    typedef struct {
        logic [RA-1:0] rd;
        logic          err;
        logic [7:0]    data;
        logic [3:0]    cc;
    } exp_t;

    exp_t          sb[$];
    int            done_cycs[$];
    int            cyc = 0;
    int            n_checks = 0;
    int            n_pass = 0;
    int            acc_cyc = 0;
    bit            saw_full = 1'b0;
    logic          mon_active = 1'b0;
    logic [RA-1:0] mon_addr = '0;
    logic [RA-1:0] stim_addr = '0;

    assign dbg_addr = mon_active ? mon_addr : stim_addr;

    alu_op_sequencer #(.DEPTH(DEPTH), .NREGS(NREGS)) dut (
        .clk(clk), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_ra(cmd_ra), .cmd_rb(cmd_rb), .cmd_rd(cmd_rd),
        .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data),
        .alu_a(alu_a), .alu_b(alu_b), .alu_n(alu_n),
        .alu_r(alu_r), .alu_cc(alu_cc), .alu_we(alu_we),
        .busy(busy), .done(done), .done_err(done_err), .done_rd(done_rd),
        .status_cc(status_cc), .dbg_addr(dbg_addr), .dbg_data(dbg_data)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Stand-in ALU
    always_comb begin
        alu_r  = 8'h00;
        alu_cc = 4'h0;
        alu_we = 1'b0;
        case (alu_n)
            4'd0, 4'd2: alu_r = alu_a + alu_b;
            4'd1:       alu_r = alu_a - alu_b;
            4'd3:       alu_r = alu_a & alu_b;
            4'd4:       alu_r = alu_a | alu_b;
            4'd5:       alu_r = alu_a ^ alu_b;
            4'd6:       alu_r = (alu_a > alu_b) ? alu_a : alu_b;
            4'd7:       alu_r = (alu_a < alu_b) ? alu_a : alu_b;
            default:    alu_r = 8'h00;
        endcase
        if (alu_n < 4'd8) begin
            alu_we = 1'b1;
            alu_cc = {alu_n >= 4'd6, 1'b0, alu_r == 8'h00, alu_n <= 4'd2};
        end
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, got, exp);
    endtask

    task automatic fail_timeout(input string name);
        n_checks++;
        $display("FAIL %s: timed out waiting for the DUT", name);
    endtask

    // Monitor: one scoreboard entry per done pulse.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!reset && done) begin
                done_cycs.push_back(cyc);
                if (sb.size() == 0) begin
                    n_checks++;
                    $display("FAIL unexpected_done: got done with rd %0d, expected no done", done_rd);
                end else begin
                    e = sb.pop_front();
                    check("done_rd", done_rd, e.rd);
                    check("done_err", done_err, e.err);
                    mon_addr   = e.rd;
                    mon_active = 1'b1;
                    @(negedge clk);
                    check("wb_data", dbg_data, e.data);
                    check("status_cc", status_cc, e.cc);
                    mon_active = 1'b0;
                end
            end
        end
    end

    task automatic ld(input logic [RA-1:0] a, input logic [7:0] d);
        @(negedge clk);
        ld_en = 1'b1; ld_addr = a; ld_data = d;
        @(posedge clk);
        #1 ld_en = 1'b0;
    endtask

    // Offers one command; the accept edge is the first posedge with ready.
    task automatic issue(input logic [3:0] op, input logic [RA-1:0] ra, input logic [RA-1:0] rb,
                         input logic [RA-1:0] rd, input logic [7:0] data, input logic [3:0] cc,
                         input logic err);
        int w;
        exp_t e;
        w = 0;
        @(negedge clk);
        while (!cmd_ready && w < 50) begin
            saw_full = 1'b1;
            w++;
            @(negedge clk);
        end
        if (!cmd_ready) begin
            fail_timeout("cmd_ready");
        end else begin
            cmd_valid = 1'b1; cmd_op = op; cmd_ra = ra; cmd_rb = rb; cmd_rd = rd;
            acc_cyc = cyc;
            e.rd = rd; e.err = err; e.data = data; e.cc = cc;
            sb.push_back(e);
            @(posedge clk);
            #1 cmd_valid = 1'b0;
        end
    endtask

    task automatic wait_done(input string name);
        int w;
        for (w = 0; w < 50; w++) begin
            @(negedge clk);
            if (done) break;
        end
        if (!done) fail_timeout(name);
    endtask

    task automatic wait_idle(input string name);
        int w;
        for (w = 0; w < 300; w++) begin
            @(negedge clk);
            if (sb.size() == 0 && !busy && !mon_active) break;
        end
        if (sb.size() != 0 || busy || mon_active) fail_timeout(name);
    endtask

    task automatic check_rf(input logic [RA-1:0] a, input logic [7:0] exp);
        stim_addr = a;
        #1 check("rf_read", dbg_data, exp);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not reach its end");
        $fatal(1);
    end

    initial begin
        int exp_gap;
        reset = 1'b1; cmd_valid = 1'b0; cmd_op = '0; cmd_ra = '0; cmd_rb = '0; cmd_rd = '0;
        ld_en = 1'b0; ld_addr = '0; ld_data = '0;

        // 1: reset state, then add with latency check
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_cmd_ready", cmd_ready, 1);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_done_err", done_err, 0);
        check("rst_done_rd", done_rd, 0);
        check("rst_alu_a", alu_a, 0);
        check("rst_alu_b", alu_b, 0);
        check("rst_alu_n", alu_n, 0);
        check("rst_status_cc", status_cc, 0);
        reset = 1'b0;
        for (int i = 0; i < NREGS; i++) check_rf(i[RA-1:0], 8'h00);

        ld(3'd1, 8'h05);
        ld(3'd2, 8'h03);
        done_cycs.delete();
        issue(4'd0, 3'd1, 3'd2, 3'd3, 8'h08, 4'b0001, 1'b0);
        wait_idle("t1");
        // Negedge before the accept edge to the negedge inside WB is 3 edges.
        if (done_cycs.size() > 0) check("latency", done_cycs[0] - acc_cyc, 3);
        else fail_timeout("latency");

        // 2: wrap to zero, then subtract
        ld(3'd1, 8'h80);
        issue(4'd2, 3'd1, 3'd1, 3'd4, 8'h00, 4'b0011, 1'b0);
        issue(4'd1, 3'd4, 3'd1, 3'd5, 8'h80, 4'b0001, 1'b0);
        wait_idle("t2");

        // 3: max / min
        ld(3'd1, 8'h05);
        ld(3'd2, 8'h09);
        issue(4'd6, 3'd1, 3'd2, 3'd6, 8'h09, 4'b1000, 1'b0);
        issue(4'd7, 3'd1, 3'd2, 3'd6, 8'h05, 4'b1000, 1'b0);
        wait_idle("t3");

        // 4: undefined opcode leaves rf[6] and status_cc alone
        issue(4'd9, 3'd1, 3'd2, 3'd6, 8'h05, 4'b1000, 1'b1);
        wait_idle("t4_err");

        // Preload colliding with a writeback to the same address is dropped
        issue(4'd3, 3'd1, 3'd2, 3'd0, 8'h01, 4'b0000, 1'b0);
        wait_done("t4_wb0");
        ld_en = 1'b1; ld_addr = 3'd0; ld_data = 8'hAA;
        @(posedge clk);
        #1 ld_en = 1'b0;
        wait_idle("t4_coll");
        // Preload to a different address during a writeback proceeds
        issue(4'd4, 3'd1, 3'd2, 3'd0, 8'h0D, 4'b0000, 1'b0);
        wait_done("t4_wb1");
        ld_en = 1'b1; ld_addr = 3'd7; ld_data = 8'h3C;
        @(posedge clk);
        #1 ld_en = 1'b0;
        wait_idle("t4_nocoll");
        check_rf(3'd7, 8'h3C);
        check_rf(3'd0, 8'h0D);

        // Back-to-back burst long enough to fill the FIFO in either build
        saw_full = 1'b0;
        issue(4'd0, 3'd1, 3'd2, 3'd3, 8'h0E, 4'b0001, 1'b0);
        issue(4'd1, 3'd1, 3'd2, 3'd4, 8'hFC, 4'b0001, 1'b0);
        issue(4'd5, 3'd1, 3'd2, 3'd5, 8'h0C, 4'b0000, 1'b0);
        issue(4'd6, 3'd1, 3'd2, 3'd6, 8'h09, 4'b1000, 1'b0);
        issue(4'd7, 3'd1, 3'd2, 3'd7, 8'h05, 4'b1000, 1'b0);
        issue(4'd3, 3'd1, 3'd2, 3'd0, 8'h01, 4'b0000, 1'b0);
        issue(4'd4, 3'd2, 3'd1, 3'd3, 8'h0D, 4'b0000, 1'b0);
        issue(4'd1, 3'd2, 3'd1, 3'd4, 8'h04, 4'b0001, 1'b0);
        wait_idle("t4_burst");
        check("saw_full", saw_full, 1);

        // 5: dependent chain r3 = r1 + r2, r7 = r3 + r3
        ld(3'd2, 8'h03);
        done_cycs.delete();
        issue(4'd0, 3'd1, 3'd2, 3'd3, 8'h08, 4'b0001, 1'b0);
        issue(4'd0, 3'd3, 3'd3, 3'd7, 8'h10, 4'b0001, 1'b0);
        wait_idle("t5");
`ifdef ALU_SEQ_FWD_EN
        exp_gap = 2;
`else
        exp_gap = 3;
`endif
        if (done_cycs.size() == 2) check("done_gap", done_cycs[1] - done_cycs[0], exp_gap);
        else fail_timeout("done_gap");

        // 6: reset while a command is in EXEC
        ld(3'd1, 8'h11);
        issue(4'd0, 3'd1, 3'd2, 3'd5, 8'h14, 4'b0001, 1'b0);
        @(negedge clk);
        @(posedge clk);
        #1;
        check("exec_busy", busy, 1);
        check("exec_alu_a", alu_a, 8'h11);
        reset = 1'b1;
        sb.delete();
        #1;
        check("mid_rst_alu_a", alu_a, 0);
        check("mid_rst_alu_n", alu_n, 0);
        check("mid_rst_done", done, 0);
        check("mid_rst_ready", cmd_ready, 1);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_status_cc", status_cc, 0);
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < NREGS; i++) check_rf(i[RA-1:0], 8'h00);
        repeat (6) @(negedge clk);
        check("post_rst_busy", busy, 0);

        ld(3'd1, 8'h02);
        ld(3'd2, 8'h03);
        issue(4'd0, 3'd1, 3'd2, 3'd1, 8'h05, 4'b0001, 1'b0);
        wait_idle("t6_after");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
